// File: rtl/processor_pkg.sv
// rtl/processor_pkg.sv - shared processor constants and iram mode encoding
//
// Purpose: constants shared between the instruction RAM and the core
// decoder (instruction width, PC width, END opcode) plus the LOAD/RUN
// mode encoding used by iram_mp.
package processor_pkg;

  localparam int NUM_CORES = 4;
  localparam int INS_W     = 21;
  localparam int DEPTH     = 64;
  localparam int ADDR_W    = 6;

  // END opcode; returned for fetches that fall past the loaded program.
  localparam logic [INS_W-1:0] END_INS = 21'b000100000000000000000;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } mode_e;

endpackage

// File: rtl/iram_fetch_port.sv
// rtl/iram_fetch_port.sv - one registered fetch port of the instruction RAM
//
// Purpose: registers one core's fetched instruction with a bounds check
// against the loaded program length.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   fetch       fetch request already qualified by RUN mode
//   pc          core program counter
//   prog_len    number of valid program words
//   rdata       RAM word at pc (combinational read from the top)
//   ins         registered instruction, held when not fetching
//   ins_valid   one-cycle valid for ins
//   addr_err    one-cycle pulse: fetched pc was >= prog_len
module iram_fetch_port #(
  parameter int                INS_W   = processor_pkg::INS_W,
  parameter int                ADDR_W  = processor_pkg::ADDR_W,
  parameter logic [INS_W-1:0]  END_INS = processor_pkg::END_INS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W:0]   prog_len,
  input  logic [INS_W-1:0]  rdata,
  output logic [INS_W-1:0]  ins,
  output logic              ins_valid,
  output logic              addr_err
);

  logic in_range;

  // prog_len is one bit wider than pc so a full program (DEPTH words) compares cleanly.
  assign in_range = ({1'b0, pc} < prog_len);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ins       <= '0;
      ins_valid <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      ins_valid <= fetch;
      addr_err  <= fetch & ~in_range;
      if (fetch) begin
        ins <= in_range ? rdata : END_INS;
      end
    end
  end

endmodule

// File: rtl/iram_mp.sv
// rtl/iram_mp.sv - multi-port instruction RAM with runtime program loading
//
// Purpose: instruction store shared by NUM_CORES cores. A loader writes the
// program through a valid/ready port in LOAD mode; the final word (load_last)
// switches to RUN mode, where every core fetches independently with one
// cycle of latency.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   load_valid/ready    write handshake; ready only in LOAD mode
//   load_addr/data/last write address, word, final-word marker
//   load_err            pulse: accepted write addressed beyond DEPTH
//   reload              return to LOAD mode and clear prog_len
//   prog_ready          high in RUN mode
//   prog_len            max written address + 1
//   fetch_en, pc        per-core fetch request and packed PCs
//   ins, ins_valid      packed fetched words and per-core valid
//   addr_err            per-core pulse: fetched pc >= prog_len
module iram_mp #(
  parameter int               NUM_CORES = processor_pkg::NUM_CORES,
  parameter int               INS_W     = processor_pkg::INS_W,
  parameter int               DEPTH     = processor_pkg::DEPTH,
  parameter int               ADDR_W    = processor_pkg::ADDR_W,
  parameter logic [INS_W-1:0] END_INS   = processor_pkg::END_INS
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        load_valid,
  output logic                        load_ready,
  input  logic [ADDR_W-1:0]           load_addr,
  input  logic [INS_W-1:0]            load_data,
  input  logic                        load_last,
  output logic                        load_err,
  input  logic                        reload,
  output logic                        prog_ready,
  output logic [ADDR_W:0]             prog_len,
  input  logic [NUM_CORES-1:0]        fetch_en,
  input  logic [NUM_CORES*ADDR_W-1:0] pc,
  output logic [NUM_CORES*INS_W-1:0]  ins,
  output logic [NUM_CORES-1:0]        ins_valid,
  output logic [NUM_CORES-1:0]        addr_err
);

  import processor_pkg::*;

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  mode_e            state_q;
  mode_e            state_d;
  logic             accept;
  logic             in_bounds;
  logic [ADDR_W:0]  wr_len;
  logic [INS_W-1:0] ram [DEPTH];

  assign load_ready = (state_q == LOAD);
  assign prog_ready = (state_q == RUN);
  assign accept     = load_valid & load_ready;
  assign in_bounds  = ({1'b0, load_addr} < DEPTH_W);
  assign wr_len     = {1'b0, load_addr} + (ADDR_W+1)'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // An out-of-range final word still completes the load; reload wins over it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD: begin
        if (!reload && accept && load_last) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (reload) begin
          state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // prog_len tracks the highest written address; it can never exceed DEPTH
  // because only in-bounds writes update it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prog_len <= '0;
      load_err <= 1'b0;
    end else begin
      load_err <= accept & ~in_bounds;
      if (reload) begin
        prog_len <= '0;
      end else if (accept && in_bounds && (wr_len > prog_len)) begin
        prog_len <= wr_len;
      end
    end
  end

  // Program storage is not reset; contents are only meaningful below prog_len.
  always_ff @(posedge clk) begin
    if (accept && in_bounds) begin
      ram[load_addr] <= load_data;
    end
  end

  // Writes happen only in LOAD and reads are only used in RUN, so the
  // combinational read ports never see a same-cycle write.
  for (genvar g = 0; g < NUM_CORES; g++) begin : g_port
    logic [ADDR_W-1:0] pc_g;
    assign pc_g = pc[g*ADDR_W +: ADDR_W];

    iram_fetch_port #(
      .INS_W   (INS_W),
      .ADDR_W  (ADDR_W),
      .END_INS (END_INS)
    ) u_port (
      .clk       (clk),
      .rst_n     (rst_n),
      .fetch     (fetch_en[g] & (state_q == RUN)),
      .pc        (pc_g),
      .prog_len  (prog_len),
      .rdata     (ram[pc_g]),
      .ins       (ins[g*INS_W +: INS_W]),
      .ins_valid (ins_valid[g]),
      .addr_err  (addr_err[g])
    );
  end

endmodule
